// File: rtl/polymul_sequencer.sv
// polymul_sequencer: four-pass scheduler (NTT A, NTT B, element-wise, inverse NTT)
// driving the polynomial_multiplication core reset, mode and BRAM bank muxes.
module polymul_sequencer #(
  parameter int LAUNCH_CYC = 2,
  parameter int TIMEOUT    = 1300,
  parameter int TO_W       = 11,
  parameter int PERF_W     = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ntt_b_en,
  input  logic              abort,
  input  logic              core_done,
  output logic              core_rst,
  output logic [1:0]        core_mode,
  output logic [1:0]        rd_bank_a,
  output logic [1:0]        rd_bank_b,
  output logic [1:0]        wr_bank,
  output logic [1:0]        step,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PERF_W-1:0] perf_cycles
);

  localparam int LC_W = (LAUNCH_CYC > 1) ? $clog2(LAUNCH_CYC) : 1;
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(LAUNCH_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] MODE_NTT = 2'b00;
  localparam logic [1:0] MODE_INV = 2'b01;
  localparam logic [1:0] MODE_EW  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_ERROR
  } state_t;

  state_t            r_state, w_state;
  logic [LC_W-1:0]   r_lcnt, w_lcnt;
  logic [TO_W-1:0]   r_wd, w_wd;
  logic [1:0]        r_step, w_step;
  logic [1:0]        w_step_nx;
  logic              r_ben, w_ben;
  logic [7:0]        r_cfg, w_cfg;
  logic              r_crst, w_crst;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_err, w_err;
  logic [PERF_W-1:0] r_cnt, w_cnt;
  logic [PERF_W-1:0] w_cnt_inc;
  logic [PERF_W-1:0] r_perf, w_perf;
  logic              w_last;

  // {mode, rd_bank_a, rd_bank_b, wr_bank} for each pass
  function automatic logic [7:0] step_cfg(input logic [1:0] s);
    logic [7:0] c;
    c = '0;
    unique case (s)
      2'd0: c = {MODE_NTT, 2'd0, 2'd0, 2'd0};
      2'd1: c = {MODE_NTT, 2'd1, 2'd1, 2'd1};
      2'd2: c = {MODE_EW,  2'd0, 2'd1, 2'd2};
      2'd3: c = {MODE_INV, 2'd2, 2'd2, 2'd2};
    endcase
    return c;
  endfunction

  assign w_step_nx = (r_step == 2'd0 && !r_ben) ? 2'd2 : r_step + 2'd1;
  assign w_last    = (r_step == 2'd3);
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + PERF_W'(1);

  always_comb begin
    w_state = r_state;
    w_lcnt  = r_lcnt;
    w_wd    = r_wd;
    w_step  = r_step;
    w_ben   = r_ben;
    w_cfg   = r_cfg;
    w_crst  = r_crst;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_err   = r_err;
    w_cnt   = r_busy ? w_cnt_inc : r_cnt;
    w_perf  = r_perf;
    unique case (r_state)
      S_IDLE: begin
        w_crst = 1'b1;
        if (start) begin
          w_state = S_LAUNCH;
          w_ben   = ntt_b_en;
          w_err   = 1'b0;
          w_step  = 2'd0;
          w_cfg   = step_cfg(2'd0);
          w_lcnt  = '0;
          w_cnt   = '0;
          w_busy  = 1'b1;
        end
      end
      S_LAUNCH: begin
        w_crst = 1'b1;
        if (abort) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
        end else if (r_lcnt == LC_LAST) begin
          w_state = S_RUN;
          w_crst  = 1'b0;
          w_wd    = '0;
        end else begin
          w_lcnt = r_lcnt + LC_W'(1);
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state = S_IDLE;
          w_crst  = 1'b1;
          w_busy  = 1'b0;
        end else if (core_done) begin
          // reassert reset at once so the core does not wrap and restart
          w_crst = 1'b1;
          if (w_last) begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_perf  = w_cnt_inc;
          end else begin
            w_state = S_LAUNCH;
            w_step  = w_step_nx;
            w_cfg   = step_cfg(w_step_nx);
            w_lcnt  = '0;
          end
        end else if (r_wd == TO_LAST) begin
          w_state = S_ERROR;
          w_crst  = 1'b1;
          w_busy  = 1'b0;
          w_err   = 1'b1;
        end else begin
          w_wd = r_wd + TO_W'(1);
        end
      end
      S_ERROR: begin
        w_state = S_IDLE;
        w_crst  = 1'b1;
      end
      default: begin
        w_state = S_IDLE;
        w_crst  = 1'b1;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lcnt  <= '0;
      r_wd    <= '0;
      r_step  <= 2'd0;
      r_ben   <= 1'b0;
      r_cfg   <= '0;
      r_crst  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_perf  <= '0;
    end else begin
      r_state <= w_state;
      r_lcnt  <= w_lcnt;
      r_wd    <= w_wd;
      r_step  <= w_step;
      r_ben   <= w_ben;
      r_cfg   <= w_cfg;
      r_crst  <= w_crst;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
      r_cnt   <= w_cnt;
      r_perf  <= w_perf;
    end
  end

  assign core_rst    = r_crst;
  assign core_mode   = r_cfg[7:6];
  assign rd_bank_a   = r_cfg[5:4];
  assign rd_bank_b   = r_cfg[3:2];
  assign wr_bank     = r_cfg[1:0];
  assign step        = r_step;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign perf_cycles = r_perf;

endmodule

// File: tb/tb_polymul_sequencer.sv
// tb_polymul_sequencer: random and directed runs of the pass scheduler
// against a pass-list reference model and a behavioural core model.
`timescale 1ns/1ps
module tb_polymul_sequencer;

  localparam int LAUNCH_CYC = 2;
  localparam int TIMEOUT    = 1300;
  localparam int PERF_W     = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              ntt_b_en = 1'b0;
  logic              abort = 1'b0;
  logic              core_done = 1'b0;
  logic              core_rst;
  logic [1:0]        core_mode;
  logic [1:0]        rd_bank_a;
  logic [1:0]        rd_bank_b;
  logic [1:0]        wr_bank;
  logic [1:0]        step;
  logic              busy;
  logic              done;
  logic              err;
  logic [PERF_W-1:0] perf_cycles;

  polymul_sequencer #(
    .LAUNCH_CYC(LAUNCH_CYC),
    .TIMEOUT(TIMEOUT),
    .TO_W(11),
    .PERF_W(PERF_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ntt_b_en(ntt_b_en),
    .abort(abort),
    .core_done(core_done),
    .core_rst(core_rst),
    .core_mode(core_mode),
    .rd_bank_a(rd_bank_a),
    .rd_bank_b(rd_bank_b),
    .wr_bank(wr_bank),
    .step(step),
    .busy(busy),
    .done(done),
    .err(err),
    .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int run_cnt = 0;
  int d_ntt = 1050;
  int d_ew = 282;
  int busy_cnt = 0;
  int done_cnt = 0;
  bit hang = 1'b0;
  bit ab_en = 1'b0;
  int ab_step = 0;
  int ab_cyc = 0;

  logic [9:0] tr_q[$];
  logic [9:0] exp_q[$];
  int         exp_d[$];
  int         exp_perf;

  int M_T[4] = '{0, 0, 2, 1};
  int A_T[4] = '{0, 1, 0, 2};
  int B_T[4] = '{0, 1, 1, 2};
  int W_T[4] = '{0, 1, 2, 2};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // core model: done after D consecutive cycles out of reset
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (core_rst) begin
      run_cnt = 0;
    end else begin
      if (run_cnt == 0)
        tr_q.push_back({step, core_mode, rd_bank_a, rd_bank_b, wr_bank});
      run_cnt++;
    end
    core_done = !core_rst && !hang &&
                run_cnt == ((core_mode == 2'b10) ? d_ew : d_ntt);
    abort = ab_en && !core_rst && step == 2'(ab_step) && run_cnt == ab_cyc;
  end

  task automatic build_exp(input bit ben);
    int d;
    exp_q.delete();
    exp_d.delete();
    exp_perf = 0;
    for (int s = 0; s < 4; s++) begin
      if (ben || s != 1) begin
        d = (M_T[s] == 2) ? d_ew : d_ntt;
        exp_q.push_back({2'(s), 2'(M_T[s]), 2'(A_T[s]), 2'(B_T[s]),
                         2'(W_T[s])});
        exp_d.push_back(d);
        exp_perf += LAUNCH_CYC + d;
      end
    end
  endtask

  task automatic do_start(input bit ben);
    tr_q.delete();
    busy_cnt = 0;
    done_cnt = 0;
    ntt_b_en = ben;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("bounded_wait_busy", busy, 0);
  endtask

  task automatic run_op(input bit ben, input int dn, input int de,
                        input bit glitch);
    d_ntt = dn;
    d_ew = de;
    hang = 1'b0;
    build_exp(ben);
    do_start(ben);
    chk("busy_after_start", busy, 1);
    chk("err_after_start", err, 0);
    if (glitch) begin
      repeat (30) @(negedge clk);
      ntt_b_en = !ben;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle(8000);
    chk("done_pulse", done, 1);
    chk("perf_cycles", perf_cycles, exp_perf);
    chk("err_clear", err, 0);
    chk("core_rst_idle", core_rst, 1);
    @(negedge clk);
    chk("done_count", done_cnt, 1);
    chk("busy_cycles", busy_cnt, exp_perf);
    chk("pass_count", tr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk("pass_cfg", (i < tr_q.size()) ? tr_q[i] : 10'h3ff, exp_q[i]);
  endtask

  task automatic abort_op(input bit ben, input int dn, input int de,
                          input int st, input int cyc);
    logic [PERF_W-1:0] p_perf;
    logic p_err;
    int exp_busy;
    bit hit;
    d_ntt = dn;
    d_ew = de;
    hang = 1'b0;
    build_exp(ben);
    exp_busy = 0;
    hit = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (!hit) begin
        if (int'(exp_q[i][9:8]) == st) begin
          exp_busy += LAUNCH_CYC + cyc;
          hit = 1'b1;
        end else begin
          exp_busy += LAUNCH_CYC + exp_d[i];
        end
      end
    end
    ab_step = st;
    ab_cyc = cyc;
    ab_en = 1'b1;
    p_perf = perf_cycles;
    p_err = err;
    do_start(ben);
    wait_idle(8000);
    chk("abort_busy", busy, 0);
    chk("abort_core_rst", core_rst, 1);
    chk("abort_no_done", done, 0);
    chk("abort_perf_kept", perf_cycles, p_perf);
    chk("abort_err_kept", err, p_err);
    chk("abort_step", step, st);
    ab_en = 1'b0;
    @(negedge clk);
    chk("abort_done_count", done_cnt, 0);
    chk("abort_busy_cycles", busy_cnt, exp_busy);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int k;
    @(negedge clk);
    @(negedge clk);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_mode", core_mode, 0);
    chk("rst_banks", {rd_bank_a, rd_bank_b, wr_bank}, 0);
    chk("rst_step", step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_perf", perf_cycles, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_op(1'b1, 1050, 282, 1'b0);
    repeat (2) @(negedge clk);
    run_op(1'b0, 1050, 282, 1'b0);
    repeat (2) @(negedge clk);

    hang = 1'b1;
    d_ntt = 1050;
    d_ew = 282;
    do_start(1'b1);
    wait_idle(3000);
    chk("timeout_err", err, 1);
    chk("timeout_core_rst", core_rst, 1);
    chk("timeout_no_done", done, 0);
    @(negedge clk);
    chk("timeout_busy_cycles", busy_cnt, LAUNCH_CYC + TIMEOUT);
    chk("timeout_done_count", done_cnt, 0);
    chk("timeout_err_sticky", err, 1);
    hang = 1'b0;
    repeat (2) @(negedge clk);
    run_op(1'b1, $urandom_range(300, 20), $urandom_range(300, 20), 1'b0);
    repeat (2) @(negedge clk);

    abort_op(1'b1, 1050, 282, 1, 500);
    repeat (2) @(negedge clk);
    abort_op(1'b1, 100, 50, 3, 100);
    repeat (2) @(negedge clk);

    run_op(1'b0, TIMEOUT, 282, 1'b0);
    repeat (2) @(negedge clk);
    run_op(1'b1, $urandom_range(400, 50), $urandom_range(400, 50), 1'b1);
    repeat (2) @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      run_op(1'($urandom_range(1, 0)), $urandom_range(400, 1),
             $urandom_range(400, 1), 1'b0);
      repeat (2) @(negedge clk);
    end

    d_ntt = 60;
    d_ew = 40;
    hang = 1'b0;
    do_start(1'b1);
    k = 0;
    while (!(step == 2'd2 && !core_rst) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("arst_reached_step2", step, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_core_rst", core_rst, 1);
    chk("arst_mode", core_mode, 0);
    chk("arst_banks", {rd_bank_a, rd_bank_b, wr_bank}, 0);
    chk("arst_step", step, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_perf", perf_cycles, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/polymul_sequencer.md
Name: polymul_sequencer

Overview:
- Top-level scheduler for the polynomial_multiplication core.
- Runs one full product in four passes: forward NTT on operand A, forward NTT on operand B (skippable), element-wise multiply, inverse NTT.
- For each pass it sets the core mode, holds the core in reset between passes, steers the BRAM bank muxes, and waits for the core done pulse.
- Sits between the cryptocore command interface and the polynomial_multiplication instance.

Parameters:
- LAUNCH_CYC, 2, cycles core_rst is held high with the new mode before each pass (must be >=1).
- TIMEOUT, 1300, maximum RUN cycles per pass before error; must exceed the longest pass (1050).
- TO_W, 11, width of the per-pass watchdog counter.
- PERF_W, 20, width of the perf_cycles counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request; accepted only in IDLE.
- ntt_b_en  in  1  1 = run pass 1 (NTT of B); 0 = B already in NTT domain. Sampled at start.
- abort  in  1  cancel the current operation.
- core_done  in  1  done pulse from polynomial_multiplication.
- core_rst  out  1  drives the core rst (active-high).
- core_mode  out  2  00 NTT, 01 inv-NTT, 10 element-wise.
- rd_bank_a  out  2  BRAM bank feeding operand slot A.
- rd_bank_b  out  2  BRAM bank feeding operand slot B.
- wr_bank  out  2  BRAM bank receiving core writes.
- step  out  2  current pass index 0..3.
- busy  out  1  high from start acceptance to done/abort/error.
- done  out  1  one-cycle pulse when the product is complete in bank 2.
- err  out  1  sticky watchdog error.
- perf_cycles  out  PERF_W  busy-cycle count of the last completed operation.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE, core_rst = 1, core_mode = 00.
  - All bank outputs = 0, step = 0.
  - busy = done = err = 0, perf_cycles = 0.
- All outputs are registered.
- States: IDLE, LAUNCH, RUN, ERROR.
- IDLE:
  - core_rst = 1.
  - On start: latch ntt_b_en, clear err, step = 0, clear the perf counter, busy = 1, go to LAUNCH.
- LAUNCH:
  - core_rst = 1 for LAUNCH_CYC cycles.
  - core_mode and banks come from the step table below and are stable before core_rst falls.
  - Then go to RUN with the watchdog = 0.
- RUN:
  - core_rst = 0; the watchdog increments each cycle.
  - On core_done sampled, core_rst = 1 the next cycle. This stops the core's wrap-around restart.
  - After the last step: go to IDLE with done = 1 for one cycle, busy = 0, perf_cycles = counter.
  - Otherwise advance step and go to LAUNCH.
- Step table (mode, rd_a, rd_b, wr):
  - step 0: NTT, 0, 0, 0.
  - step 1: NTT, 1, 1, 1.
  - step 2: element-wise, 0, 1, 2.
  - step 3: inv-NTT, 2, 2, 2.
- If the latched ntt_b_en = 0, step 0 advances directly to step 2.
- Watchdog:
  - If the watchdog reaches TIMEOUT without core_done: go to ERROR, err = 1, core_rst = 1, busy = 0, no done.
  - ERROR returns to IDLE next cycle; err stays 1 until the next accepted start or rst.
- abort:
  - In LAUNCH or RUN: next state IDLE, core_rst = 1, busy = 0, no done, err unchanged, perf_cycles unchanged.
  - abort in IDLE is ignored.
- Priorities:
  - abort beats core_done and the watchdog in the same cycle.
  - core_done beats the watchdog expiring in the same cycle.
  - start while busy is ignored.
  - core_done outside RUN is ignored.
- perf_cycles counts every cycle with busy = 1, including LAUNCH cycles and the done-sample cycle. It saturates at all-ones.
- Pass occupancy is LAUNCH_CYC + D, where D = RUN cycles up to and including the core_done cycle.
- rst mid-operation: immediate return to reset values; the core is held in reset.

Test Plan:
- Full run: core model pulses done at RUN cycle 1050 (NTT) or 282 (element-wise); start with ntt_b_en = 1.
  - Required: core_mode sequence 00, 00, 10, 01.
  - Required: wr_bank sequence 0, 1, 2, 2; a single done pulse; perf_cycles = 3440.
- Skip B: same model with ntt_b_en = 0.
  - Required: steps 0, 2, 3; modes 00, 10, 01; perf_cycles = 2388.
- Timeout: model never pulses done.
  - Required: err = 1 after 2 + 1300 busy cycles; busy = 0; core_rst = 1; no done.
  - A following start clears err and completes normally.
- Abort: abort asserted at RUN cycle 500 of step 1.
  - Required: IDLE next cycle, core_rst = 1, no done, perf_cycles keeps its previous value.
  - abort together with core_done in the same cycle also yields no done.
- Collisions:
  - core_done and watchdog expiry in the same cycle -> the pass advances, err stays 0.
  - start pulsed while busy -> ignored; step sequence unchanged.
- Async reset asserted during step 2 between clock edges.
  - Required: all outputs at reset values immediately, before the next edge; core_rst = 1.
